// File: rtl/arr_mem_pkg.sv
// arr_mem_pkg: shared types and constants for the array memory port controller.
package arr_mem_pkg;
   typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
endpackage

// File: rtl/arr_mem_core.sv
// arr_mem_core: single-port word storage with a registered read and selectable read-during-write result.
module arr_mem_core
   import arr_mem_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 2,
   parameter int RDW_MODE = RDW_WRITE_FIRST,
   localparam int AW      = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic                    re,
   input  logic [AW-1:0]           addr,
   input  logic signed [WIDTH-1:0] wdata,
   output logic signed [WIDTH-1:0] rdata
);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   logic signed [WIDTH-1:0] mem_q [DEPTH];
   logic signed [WIDTH-1:0] rdata_q, rdata_d;
   logic in_range;
   assign in_range = {1'b0, addr} < DEPTH_W;
   always_comb rdata_d = !in_range ? '0 : (we && RDW_MODE == RDW_WRITE_FIRST) ? wdata : mem_q[addr];
   // storage is deliberately left out of reset
   always_ff @(posedge clk)
      if (we && in_range) mem_q[addr] <= wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata_q <= '0;
      else if (re) rdata_q <= rdata_d;
   assign rdata = rdata_q;
endmodule

// File: rtl/arr_mem_port_ctrl.sv
// arr_mem_port_ctrl: host/datapath arbitration, clear sequencer and read steering around one array.
module arr_mem_port_ctrl
   import arr_mem_pkg::*;
#(
   parameter int              WIDTH    = 64,
   parameter int              DEPTH    = 2,
   parameter int              RDW_MODE = RDW_WRITE_FIRST,
   parameter logic [WIDTH-1:0] CLR_VAL = '0,
   localparam int             AW       = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ctrl_sel,
   input  logic                    ctrl_we,
   input  logic [AW-1:0]           ctrl_addr,
   input  logic signed [WIDTH-1:0] ctrl_wdata,
   output logic signed [WIDTH-1:0] ctrl_rdata,
   input  logic                    dp_re,
   input  logic                    dp_we,
   input  logic [AW-1:0]           dp_addr,
   input  logic signed [WIDTH-1:0] dp_wdata,
   output logic signed [WIDTH-1:0] dp_rdata,
   output logic                    dp_rvalid,
   input  logic                    clr_req,
   output logic                    clr_busy,
   output logic                    dp_drop
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   clr_state_t state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d, mem_addr;
   logic host_g, dp_g, mem_we, mem_re;
   logic ctrl_rd_q, ctrl_rd_d, dp_rvalid_q, dp_rvalid_d, dp_drop_q, dp_drop_d;
   logic signed [WIDTH-1:0] mem_wdata, mem_rdata, ctrl_hold_q, dp_hold_q;
   assign clr_busy = state_q == CLR_RUN;
   assign host_g   = !clr_busy && ctrl_sel;
   assign dp_g     = !clr_busy && !ctrl_sel;
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      if (clr_busy) begin
         state_d = ptr_q == LAST ? CLR_IDLE : CLR_RUN;
         ptr_d   = ptr_q == LAST ? '0 : ptr_q + 1'b1;
      end else if (clr_req) begin
         state_d = CLR_RUN;
         ptr_d   = '0;
      end
      mem_we      = clr_busy || (host_g && ctrl_we) || (dp_g && dp_we);
      mem_re      = (host_g && !ctrl_we) || (dp_g && dp_re);
      mem_addr    = clr_busy ? ptr_q : host_g ? ctrl_addr : dp_addr;
      mem_wdata   = clr_busy ? CLR_VAL : host_g ? ctrl_wdata : dp_wdata;
      ctrl_rd_d   = host_g && !ctrl_we;
      dp_rvalid_d = dp_g && dp_re;
      dp_drop_d   = !dp_g && (dp_re || dp_we);
   end
   arr_mem_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RDW_MODE(RDW_MODE)) u_core (
      .clk(clk), .rst_n(rst_n), .we(mem_we), .re(mem_re),
      .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata)
   );
   // the shared read register serves whichever port read last; the other port shows its held copy
   assign ctrl_rdata = ctrl_rd_q ? mem_rdata : ctrl_hold_q;
   assign dp_rdata   = dp_rvalid_q ? mem_rdata : dp_hold_q;
   assign dp_rvalid  = dp_rvalid_q;
   assign dp_drop    = dp_drop_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= CLR_IDLE;
         ptr_q       <= '0;
         ctrl_rd_q   <= 1'b0;
         dp_rvalid_q <= 1'b0;
         dp_drop_q   <= 1'b0;
         ctrl_hold_q <= '0;
         dp_hold_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         ctrl_rd_q   <= ctrl_rd_d;
         dp_rvalid_q <= dp_rvalid_d;
         dp_drop_q   <= dp_drop_d;
         ctrl_hold_q <= ctrl_rdata;
         dp_hold_q   <= dp_rdata;
      end
endmodule
